// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the hazard controller and the ALU operand muxes.
package hazard_ctrl_pkg;

  typedef logic [1:0] hz_state_t;
  typedef logic [1:0] fwd_sel_t;

  // Controller state encodings (legacy numeric values kept)
  localparam hz_state_t ST_RUN    = 2'd0;
  localparam hz_state_t ST_LSTALL = 2'd1;
  localparam hz_state_t ST_MWAIT  = 2'd2;
  localparam hz_state_t ST_HALT   = 2'd3;

  // ALU operand source selects
  localparam fwd_sel_t FWD_RF  = 2'b00;
  localparam fwd_sel_t FWD_MEM = 2'b01;
  localparam fwd_sel_t FWD_WB  = 2'b10;

  // Pick the operand source for one EX source register; MEM is younger
  // than WB so it wins, and x0 is never forwarded.
  function automatic fwd_sel_t fwd_pick(input logic [4:0] rs,
                                        input logic [4:0] mem_rd,
                                        input logic       mem_wr,
                                        input logic [4:0] wb_rd,
                                        input logic       wb_wr);
    fwd_sel_t sel;
    sel = FWD_RF;
    if (mem_wr && (mem_rd != 5'd0) && (mem_rd == rs))
      sel = FWD_MEM;
    else if (wb_wr && (wb_rd != 5'd0) && (wb_rd == rs))
      sel = FWD_WB;
    return sel;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle.
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);

  // pipeline status into the controller
  logic             Mwk;
  logic [4:0]       ID_rs1;
  logic [4:0]       ID_rs2;
  logic             ID_use1;
  logic             ID_use2;
  logic [4:0]       EX_rs1;
  logic [4:0]       EX_rs2;
  logic [4:0]       EX_rd;
  logic             EX_RegWr;
  logic             EX_MemRd;
  logic             EX_PCSrc;
  logic [4:0]       MEM_rd;
  logic             MEM_RegWr;
  logic             MEM_busy;
  logic [4:0]       WB_rd;
  logic             WB_RegWr;

  // pipeline controls out of the controller
  logic             PC_en;
  logic             IFID_en;
  logic             IFID_flush;
  logic             IDEX_en;
  logic             IDEX_flush;
  logic             EXMEM_en;
  logic [1:0]       FwdA;
  logic [1:0]       FwdB;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // pipeline side
  modport master (
    output Mwk, ID_rs1, ID_rs2, ID_use1, ID_use2,
           EX_rs1, EX_rs2, EX_rd, EX_RegWr, EX_MemRd, EX_PCSrc,
           MEM_rd, MEM_RegWr, MEM_busy, WB_rd, WB_RegWr,
    input  PC_en, IFID_en, IFID_flush, IDEX_en, IDEX_flush, EXMEM_en,
           FwdA, FwdB, state, stall_cnt, flush_cnt
  );

  // controller side
  modport slave (
    input  Mwk, ID_rs1, ID_rs2, ID_use1, ID_use2,
           EX_rs1, EX_rs2, EX_rd, EX_RegWr, EX_MemRd, EX_PCSrc,
           MEM_rd, MEM_RegWr, MEM_busy, WB_rd, WB_RegWr,
    output PC_en, IFID_en, IFID_flush, IDEX_en, IDEX_flush, EXMEM_en,
           FwdA, FwdB, state, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/hazard_ctrl_fwd_unit.sv
// Combinational ALU operand forwarding selects for the EX stage.
module fwd_unit
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] ex_rs1,
  input  logic [4:0] ex_rs2,
  input  logic [4:0] mem_rd,
  input  logic       mem_regwr,
  input  logic [4:0] wb_rd,
  input  logic       wb_regwr,
  output fwd_sel_t   fwd_a,
  output fwd_sel_t   fwd_b
);

  // independent select per operand, same priority rule for both
  always_comb begin
    fwd_a = fwd_pick(ex_rs1, mem_rd, mem_regwr, wb_rd, wb_regwr);
    fwd_b = fwd_pick(ex_rs2, mem_rd, mem_regwr, wb_rd, wb_regwr);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes, memory
// wait, halt, plus stall/flush performance counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned LD_STALL = 1,
  parameter int unsigned CNT_W    = 16
) (
  input logic         CLK,
  input logic         RST_N,
  hazard_ctrl_if.slave hif
);

  localparam logic [1:0] LD_LOAD = 2'(LD_STALL - 1);

  hz_state_t        state_q, state_d;
  logic [1:0]       lcnt_q, lcnt_d;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             load_use;
  logic             bubble;
  logic             redirect;
  logic             pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en;

  // load in EX whose destination is read by the instruction in ID
  always_comb begin
    load_use = hif.EX_MemRd && hif.EX_RegWr && (hif.EX_rd != 5'd0) &&
               ((hif.ID_use1 && (hif.ID_rs1 == hif.EX_rd)) ||
                (hif.ID_use2 && (hif.ID_rs2 == hif.EX_rd)));
  end

  // next state, bubble counter and pipeline controls; priority is
  // halt > memory wait > taken branch > load-use
  always_comb begin
    state_d    = state_q;
    lcnt_d     = lcnt_q;
    bubble     = 1'b0;
    redirect   = 1'b0;
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_en    = 1'b1;
    idex_flush = 1'b0;
    exmem_en   = 1'b1;

    if (!hif.Mwk) begin
      state_d  = ST_HALT;
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
    end else if (state_q == ST_HALT) begin
      state_d = ST_RUN;
      lcnt_d  = '0;
    end else if (hif.MEM_busy) begin
      // freeze everything; lcnt_q is kept so an interrupted stall resumes
      state_d  = ST_MWAIT;
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (hif.EX_PCSrc) begin
            redirect = 1'b1;
          end else if (load_use) begin
            bubble = 1'b1;
            if (LD_STALL > 1) begin
              state_d = ST_LSTALL;
              lcnt_d  = LD_LOAD;
            end
          end
        end
        ST_LSTALL: begin
          bubble = 1'b1;
          if (lcnt_q <= 2'd1) begin
            state_d = ST_RUN;
            lcnt_d  = '0;
          end else begin
            lcnt_d = lcnt_q - 2'd1;
          end
        end
        ST_MWAIT: begin
          state_d = (lcnt_q != 2'd0) ? ST_LSTALL : ST_RUN;
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end

    if (bubble) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
    if (redirect) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end
  end

  // state register and remaining-bubble counter
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_RUN;
      lcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      lcnt_q  <= lcnt_d;
    end
  end

  // saturating count of bubble-inserting cycles
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      stall_q <= '0;
    else if (bubble && (stall_q != '1))
      stall_q <= stall_q + CNT_W'(1);
  end

  // saturating count of branch-redirect flush cycles
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      flush_q <= '0;
    else if (redirect && (flush_q != '1))
      flush_q <= flush_q + CNT_W'(1);
  end

  // drive the bundle
  always_comb begin
    hif.PC_en      = pc_en;
    hif.IFID_en    = ifid_en;
    hif.IFID_flush = ifid_flush;
    hif.IDEX_en    = idex_en;
    hif.IDEX_flush = idex_flush;
    hif.EXMEM_en   = exmem_en;
    hif.state      = state_q;
    hif.stall_cnt  = stall_q;
    hif.flush_cnt  = flush_q;
  end

  fwd_unit u_fwd (
    .ex_rs1    (hif.EX_rs1),
    .ex_rs2    (hif.EX_rs2),
    .mem_rd    (hif.MEM_rd),
    .mem_regwr (hif.MEM_RegWr),
    .wb_rd     (hif.WB_rd),
    .wb_regwr  (hif.WB_RegWr),
    .fwd_a     (hif.FwdA),
    .fwd_b     (hif.FwdB)
  );

endmodule
